// File: rtl/issue_pkg.sv
// Shared types and constants for the micro-instruction issue unit.
// Instruction word layout: {op[19:15], ar2[14:10], ar1[9:5], aw[4:0]}.
package issue_pkg;

  localparam int BUS_W = 20;
  localparam int DEPTH = 32;
  localparam int PC_W  = $clog2(DEPTH);

  localparam logic [4:0] HALT_OP = 5'b11111;

  localparam int OP_HI  = 19;
  localparam int OP_LO  = 15;
  localparam int AR2_HI = 14;
  localparam int AR2_LO = 10;
  localparam int AR1_HI = 9;
  localparam int AR1_LO = 5;
  localparam int AW_HI  = 4;
  localparam int AW_LO  = 0;

  typedef logic [BUS_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  function automatic logic [4:0] word_op(input word_t w);
    return w[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Program store: one synchronous write port, one synchronous 1-cycle read port.
// No reset on the array or read register so it maps onto block RAM.
module instr_mem #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_issue_unit.sv
// Steps a PC through the loaded program, presenting each non-halt word on the
// datapath bus with a one-cycle wreg commit pulse (one instruction per 2 cycles).
module instr_issue_unit
  import issue_pkg::*;
#(
  parameter int         DEPTH   = issue_pkg::DEPTH,
  parameter int         PC_W    = $clog2(DEPTH),
  parameter logic [4:0] HALT_OP = issue_pkg::HALT_OP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             prog_we,
  input  logic [PC_W-1:0]  prog_addr,
  input  logic [BUS_W-1:0] prog_data,
  output logic [BUS_W-1:0] bus,
  output logic             wreg,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             halted
);

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [BUS_W-1:0] bus_q, bus_d;
  logic             wreg_q, wreg_d;

  logic             mem_we;
  logic             mem_re;
  logic [BUS_W-1:0] mem_rdata;
  logic             pc_last;

  instr_mem #(
    .DEPTH (DEPTH),
    .AW    (PC_W),
    .WIDTH (BUS_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (mem_re),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  assign pc_last = (pc_q == PC_W'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bus_d   = bus_q;
    wreg_d  = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;

    case (state_q)
      IDLE, HALT: begin
        mem_we = prog_we;
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end

      // Reading every FETCH cycle means a stalled read is simply re-issued.
      FETCH: begin
        mem_re = 1'b1;
        if (!stall) begin
          state_d = ISSUE;
        end
      end

      // Consuming a word (halt or not) advances pc, but it never wraps past the end.
      ISSUE: begin
        if (!stall) begin
          pc_d = pc_last ? pc_q : pc_q + PC_W'(1);
          if (word_op(mem_rdata) == HALT_OP) begin
            state_d = HALT;
          end else begin
            bus_d   = mem_rdata;
            wreg_d  = 1'b1;
            state_d = pc_last ? HALT : FETCH;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      bus_q   <= '0;
      wreg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bus_q   <= bus_d;
      wreg_q  <= wreg_d;
    end
  end

  assign bus    = bus_q;
  assign wreg   = wreg_q;
  assign pc     = pc_q;
  assign busy   = (state_q == FETCH) || (state_q == ISSUE);
  assign halted = (state_q == HALT);

endmodule
